forward_hazard_unit: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit for the or1300 pipeline, replacing the fixed single-stage forwarding scheme. It tracks the destinations of the last `DEPTH` issued instructions, registers per-operand forwarding selects for the execute stage, and forwards register-file write-back and data-cache load returns to the decode/register-fetch stage. It also raises a load-use stall and inserts a bubble when a consumer needs load data before it exists.

---
 rtl/forward_hazard_unit_pkg.sv | 22 ++
 rtl/forward_hazard_unit_match.sv | 43 ++++
 rtl/forward_hazard_unit.sv | 147 ++++++++++++++
 tb/tb_forward_hazard_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_hazard_unit_pkg.sv
// Shared tracker-entry layout and parameter legality helper for the forwarding unit.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package forward_hazard_unit_pkg;

    // Tracker entry layout, LSB first: dest[RAW-1:0], then the flag bits below at RAW+offset.
    localparam int TRK_FLAG_ISLOAD = 0;
    localparam int TRK_FLAG_WE     = 1;
    localparam int TRK_FLAG_VALID  = 2;
    localparam int TRK_NUM_FLAGS   = 3;

    // Width of one tracker entry for a given register-address width.
    function automatic int trkEntryWidth(input int raw);
        return raw + TRK_NUM_FLAGS;
    endfunction

    // DEPTH must be 2..6 and the load-data stage must lie inside the tracked window.
    function automatic bit fwdParamsLegal(input int depth, input int loadStage);
        return (depth >= 2) && (depth <= 6) && (loadStage >= 1) && (loadStage <= depth - 1);
    endfunction

endpackage

// File: rtl/forward_hazard_unit_match.sv
// Priority encoder: finds the youngest valid, writing tracker entry whose dest equals one operand.
// Latency: combinational.
// Backpressure: none; pure function of the tracker contents and the operand.
module forward_operand_match
    import forward_hazard_unit_pkg::*;
#(
    parameter int RAW   = 5,
    parameter int DEPTH = 3,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH*(RAW+TRK_NUM_FLAGS)-1:0] trackerFlat,
    input  logic                                 enable,
    input  logic [RAW-1:0]                       operandAddr,
    output logic                                 match,
    output logic [IDX_W-1:0]                     index,
    output logic                                 isLoad
);

    localparam int EW = RAW + TRK_NUM_FLAGS;

    logic [EW-1:0] entry;

    // Scan oldest-to-youngest so the youngest hit (lowest index) overwrites older ones.
    // The write-back slot (DEPTH-1) is excluded: the register-file path covers it.
    always_comb begin
        match  = 1'b0;
        index  = '0;
        isLoad = 1'b0;
        entry  = '0;
        if (enable && (operandAddr != '0)) begin
            for (int k = DEPTH - 2; k >= 0; k--) begin
                entry = trackerFlat[k*EW +: EW];
                if (entry[RAW+TRK_FLAG_VALID] && entry[RAW+TRK_FLAG_WE] &&
                    (entry[RAW-1:0] == operandAddr)) begin
                    match  = 1'b1;
                    index  = IDX_W'(k);
                    isLoad = entry[RAW+TRK_FLAG_ISLOAD];
                end
            end
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and load-use hazard detection over the last DEPTH issued instructions.
// Latency: EXE selects 1 cycle after ID match; RF forwarding and hazardStall are combinational.
// Backpressure: stall holds all state; hazardStall asks IF/ID to hold and inserts a bubble.
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAW        = 5,
    parameter int CID_WIDTH  = 4,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            stall,
    input  logic                            flush,
    input  logic [RAW-1:0]                  idOperandAAddr,
    input  logic [RAW-1:0]                  idOperandBAddr,
    input  logic                            idUseImmediate,
    input  logic                            idIsJump,
    input  logic                            idIsStore,
    input  logic                            idIsLoad,
    input  logic [RAW-1:0]                  idDestination,
    input  logic                            idWeDestination,
    input  logic [DEPTH*DATA_WIDTH-1:0]     stageData,
    input  logic [CID_WIDTH+RAW-1:0]        dcacheRegisterAddress,
    input  logic                            dcacheRegisterWe,
    input  logic [DATA_WIDTH-1:0]           dcacheRegisterData,
    input  logic [CID_WIDTH-1:0]            cid,
    input  logic [RAW-1:0]                  writeAddress,
    input  logic                            writeEnable,
    input  logic [DATA_WIDTH-1:0]           writeData,
    output logic [DATA_WIDTH-1:0]           exeOperandA,
    output logic [DATA_WIDTH-1:0]           exeOperandB,
    output logic [DATA_WIDTH-1:0]           exeStoreData,
    output logic                            exeUseForwardedOpA,
    output logic                            exeUseForwardedOpB,
    output logic                            exeUseForwardedStoreData,
    output logic [DATA_WIDTH-1:0]           rfForwardedOperandA,
    output logic [DATA_WIDTH-1:0]           rfForwardedOperandB,
    output logic [DATA_WIDTH-1:0]           rfForwardedStoreData,
    output logic                            rfUseForwardedOpA,
    output logic                            rfUseForwardedOpB,
    output logic                            rfUseForwardedStoreData,
    output logic                            hazardStall
);

    localparam int EW    = trkEntryWidth(RAW);
    localparam int IDX_W = $clog2(DEPTH);

    if (!fwdParamsLegal(DEPTH, LOAD_STAGE)) begin : gIllegalParams
        $error("forward_hazard_unit: DEPTH must be 2..6 and LOAD_STAGE 1..DEPTH-1");
    end

    logic [EW-1:0]          tracker [DEPTH];
    logic [DEPTH*EW-1:0]    trackerFlat;
    logic [DATA_WIDTH-1:0]  stageSlice [DEPTH];
    logic [IDX_W-1:0]       selA, selB, selS;

    for (genvar k = 0; k < DEPTH; k++) begin : gFlatten
        assign trackerFlat[k*EW +: EW] = tracker[k];
        assign stageSlice[k]           = stageData[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Operand enables; register 0 is hardwired and never forwarded.
    logic enA, enB, enS;
    assign enA = !idIsJump       && (idOperandAAddr != '0);
    assign enB = !idUseImmediate && (idOperandBAddr != '0);
    assign enS = idIsStore       && (idOperandBAddr != '0);

    logic             matchA, matchB, matchS;
    logic [IDX_W-1:0] idxA, idxB, idxS;
    logic             loadA, loadB, loadS;

    forward_operand_match #(.RAW(RAW), .DEPTH(DEPTH), .IDX_W(IDX_W)) uMatchA (
        .trackerFlat(trackerFlat), .enable(enA), .operandAddr(idOperandAAddr),
        .match(matchA), .index(idxA), .isLoad(loadA)
    );
    forward_operand_match #(.RAW(RAW), .DEPTH(DEPTH), .IDX_W(IDX_W)) uMatchB (
        .trackerFlat(trackerFlat), .enable(enB), .operandAddr(idOperandBAddr),
        .match(matchB), .index(idxB), .isLoad(loadB)
    );
    forward_operand_match #(.RAW(RAW), .DEPTH(DEPTH), .IDX_W(IDX_W)) uMatchS (
        .trackerFlat(trackerFlat), .enable(enS), .operandAddr(idOperandBAddr),
        .match(matchS), .index(idxS), .isLoad(loadS)
    );

    // A load at tracker[k] is usable from EXE only once it has reached LOAD_STAGE.
    logic luA, luB, luS, killId;
    assign luA         = matchA && loadA && ((int'(idxA) + 1) < LOAD_STAGE);
    assign luB         = matchB && loadB && ((int'(idxB) + 1) < LOAD_STAGE);
    assign luS         = matchS && loadS && ((int'(idxS) + 1) < LOAD_STAGE);
    assign hazardStall = !flush && (luA || luB || luS);
    assign killId      = flush || hazardStall;

    // Shift the tracker and register the EXE selects; a killed ID slot becomes a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                tracker[k] <= '0;
            end
            selA                     <= '0;
            selB                     <= '0;
            selS                     <= '0;
            exeUseForwardedOpA       <= 1'b0;
            exeUseForwardedOpB       <= 1'b0;
            exeUseForwardedStoreData <= 1'b0;
        end else if (!stall) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                tracker[k] <= tracker[k-1];
            end
            tracker[0] <= killId ? '0 : {1'b1, idWeDestination, idIsLoad, idDestination};
            exeUseForwardedOpA       <= matchA && !killId;
            exeUseForwardedOpB       <= matchB && !killId;
            exeUseForwardedStoreData <= matchS && !killId;
            selA <= (matchA && !killId) ? idxA + IDX_W'(1) : '0;
            selB <= (matchB && !killId) ? idxB + IDX_W'(1) : '0;
            selS <= (matchS && !killId) ? idxS + IDX_W'(1) : '0;
        end
    end

    assign exeOperandA  = stageSlice[selA];
    assign exeOperandB  = stageSlice[selB];
    assign exeStoreData = stageSlice[selS];

    // Register-file path: a late dcache return for this context beats the write port.
    logic           dcCidHit;
    logic [RAW-1:0] dcReg;
    logic           dcHitA, dcHitB, dcHitS, wbHitA, wbHitB, wbHitS;

    assign dcCidHit = dcacheRegisterWe && (dcacheRegisterAddress[CID_WIDTH+RAW-1:RAW] == cid);
    assign dcReg    = dcacheRegisterAddress[RAW-1:0];
    assign dcHitA   = enA && dcCidHit && (dcReg == idOperandAAddr);
    assign dcHitB   = enB && dcCidHit && (dcReg == idOperandBAddr);
    assign dcHitS   = enS && dcCidHit && (dcReg == idOperandBAddr);
    assign wbHitA   = enA && writeEnable && (writeAddress == idOperandAAddr);
    assign wbHitB   = enB && writeEnable && (writeAddress == idOperandBAddr);
    assign wbHitS   = enS && writeEnable && (writeAddress == idOperandBAddr);

    assign rfUseForwardedOpA       = dcHitA || wbHitA;
    assign rfUseForwardedOpB       = dcHitB || wbHitB;
    assign rfUseForwardedStoreData = dcHitS || wbHitS;
    assign rfForwardedOperandA     = dcHitA ? dcacheRegisterData : writeData;
    assign rfForwardedOperandB     = dcHitB ? dcacheRegisterData : writeData;
    assign rfForwardedStoreData    = dcHitS ? dcacheRegisterData : writeData;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed scenarios followed by random traffic against a reference model.
// Latency: model predicts EXE selects one cycle after the ID match, RF/hazard outputs same cycle.
// Backpressure: stall, flush and reset are randomised alongside the instruction stream.
module tb_forward_hazard_unit;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int DEPTH = 3;
    localparam int LOAD_STAGE = 2;

    logic               clock = 1'b0;
    logic               reset, stall, flush;
    logic [RW-1:0]      idOperandAAddr, idOperandBAddr, idDestination;
    logic               idUseImmediate, idIsJump, idIsStore, idIsLoad, idWeDestination;
    logic [DEPTH*DW-1:0] stageData;
    logic [CW+RW-1:0]   dcacheRegisterAddress;
    logic               dcacheRegisterWe;
    logic [DW-1:0]      dcacheRegisterData;
    logic [CW-1:0]      cid;
    logic [RW-1:0]      writeAddress;
    logic               writeEnable;
    logic [DW-1:0]      writeData;
    logic [DW-1:0]      exeOperandA, exeOperandB, exeStoreData;
    logic               exeUseForwardedOpA, exeUseForwardedOpB, exeUseForwardedStoreData;
    logic [DW-1:0]      rfForwardedOperandA, rfForwardedOperandB, rfForwardedStoreData;
    logic               rfUseForwardedOpA, rfUseForwardedOpB, rfUseForwardedStoreData;
    logic               hazardStall;

    always #5 clock = ~clock;

    forward_hazard_unit #(
        .DATA_WIDTH(DW), .RAW(RW), .CID_WIDTH(CW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .idOperandAAddr(idOperandAAddr), .idOperandBAddr(idOperandBAddr),
        .idUseImmediate(idUseImmediate), .idIsJump(idIsJump), .idIsStore(idIsStore),
        .idIsLoad(idIsLoad), .idDestination(idDestination), .idWeDestination(idWeDestination),
        .stageData(stageData),
        .dcacheRegisterAddress(dcacheRegisterAddress), .dcacheRegisterWe(dcacheRegisterWe),
        .dcacheRegisterData(dcacheRegisterData), .cid(cid),
        .writeAddress(writeAddress), .writeEnable(writeEnable), .writeData(writeData),
        .exeOperandA(exeOperandA), .exeOperandB(exeOperandB), .exeStoreData(exeStoreData),
        .exeUseForwardedOpA(exeUseForwardedOpA), .exeUseForwardedOpB(exeUseForwardedOpB),
        .exeUseForwardedStoreData(exeUseForwardedStoreData),
        .rfForwardedOperandA(rfForwardedOperandA), .rfForwardedOperandB(rfForwardedOperandB),
        .rfForwardedStoreData(rfForwardedStoreData),
        .rfUseForwardedOpA(rfUseForwardedOpA), .rfUseForwardedOpB(rfUseForwardedOpB),
        .rfUseForwardedStoreData(rfUseForwardedStoreData),
        .hazardStall(hazardStall)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: history of issued instructions, youngest first.
    typedef struct {
        bit       valid;
        bit       we;
        bit       isLoad;
        bit [4:0] dest;
    } instr_t;

    instr_t hist [DEPTH];
    bit     mUseA, mUseB, mUseS;
    int     mSrcA, mSrcB, mSrcS;

    function automatic logic [DW-1:0] slice(input int k);
        return stageData[k*DW +: DW];
    endfunction

    // Position of the youngest in-flight producer (excluding write-back), or -1.
    function automatic int producerOf(input bit en, input logic [RW-1:0] addr);
        if (!en || addr == 0) return -1;
        for (int k = 0; k <= DEPTH - 2; k++)
            if (hist[k].valid && hist[k].we && hist[k].dest == addr) return k;
        return -1;
    endfunction

    function automatic bit needsStall(input int k);
        return (k >= 0) && hist[k].isLoad && (k + 1 < LOAD_STAGE);
    endfunction

    function automatic bit modelHazard();
        if (flush) return 0;
        return needsStall(producerOf(!idIsJump, idOperandAAddr)) ||
               needsStall(producerOf(!idUseImmediate, idOperandBAddr)) ||
               needsStall(producerOf(idIsStore, idOperandBAddr));
    endfunction

    function automatic bit dcHit(input bit en, input logic [RW-1:0] addr);
        return en && addr != 0 && dcacheRegisterWe &&
               dcacheRegisterAddress[CW+RW-1:RW] == cid && dcacheRegisterAddress[RW-1:0] == addr;
    endfunction

    function automatic bit wbHit(input bit en, input logic [RW-1:0] addr);
        return en && addr != 0 && writeEnable && writeAddress == addr;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < DEPTH; k++) hist[k] = '{0, 0, 0, 0};
        mUseA = 0; mUseB = 0; mUseS = 0;
        mSrcA = 0; mSrcB = 0; mSrcS = 0;
    endtask

    task automatic modelClock();
        int pA, pB, pS;
        bit kill;
        if (reset) begin
            modelReset();
        end else if (!stall) begin
            pA = producerOf(!idIsJump, idOperandAAddr);
            pB = producerOf(!idUseImmediate, idOperandBAddr);
            pS = producerOf(idIsStore, idOperandBAddr);
            kill = flush || modelHazard();
            mUseA = (pA >= 0) && !kill; mSrcA = pA + 1;
            mUseB = (pB >= 0) && !kill; mSrcB = pB + 1;
            mUseS = (pS >= 0) && !kill; mSrcS = pS + 1;
            for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
            if (kill) hist[0] = '{0, 0, 0, 0};
            else      hist[0] = '{1, idWeDestination, idIsLoad, idDestination};
        end
    endtask

    task automatic compareAll();
        bit eA, eB, eS;
        eA = !idIsJump; eB = !idUseImmediate; eS = idIsStore;
        checkEq("hazardStall", hazardStall, modelHazard());
        checkEq("rfUseA", rfUseForwardedOpA, dcHit(eA, idOperandAAddr) || wbHit(eA, idOperandAAddr));
        checkEq("rfUseB", rfUseForwardedOpB, dcHit(eB, idOperandBAddr) || wbHit(eB, idOperandBAddr));
        checkEq("rfUseS", rfUseForwardedStoreData, dcHit(eS, idOperandBAddr) || wbHit(eS, idOperandBAddr));
        if (rfUseForwardedOpA)
            checkEq("rfValA", rfForwardedOperandA,
                    dcHit(eA, idOperandAAddr) ? dcacheRegisterData : writeData);
        if (rfUseForwardedOpB)
            checkEq("rfValB", rfForwardedOperandB,
                    dcHit(eB, idOperandBAddr) ? dcacheRegisterData : writeData);
        if (rfUseForwardedStoreData)
            checkEq("rfValS", rfForwardedStoreData,
                    dcHit(eS, idOperandBAddr) ? dcacheRegisterData : writeData);
        checkEq("exeUseA", exeUseForwardedOpA, mUseA);
        checkEq("exeUseB", exeUseForwardedOpB, mUseB);
        checkEq("exeUseS", exeUseForwardedStoreData, mUseS);
        if (mUseA) checkEq("exeValA", exeOperandA, slice(mSrcA));
        if (mUseB) checkEq("exeValB", exeOperandB, slice(mSrcB));
        if (mUseS) checkEq("exeValS", exeStoreData, slice(mSrcS));
    endtask

    // Entered just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        #1;
        compareAll();
        @(posedge clock);
        modelClock();
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0;
        idOperandAAddr = 0; idOperandBAddr = 0; idDestination = 0;
        idUseImmediate = 0; idIsJump = 0; idIsStore = 0; idIsLoad = 0; idWeDestination = 0;
        dcacheRegisterAddress = 0; dcacheRegisterWe = 0; dcacheRegisterData = 0; cid = 0;
        writeAddress = 0; writeEnable = 0; writeData = 0;
    endtask

    task automatic issue(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [RW-1:0] d,
                         input bit we, input bit ld);
        idOperandAAddr = a; idOperandBAddr = b; idDestination = d;
        idWeDestination = we; idIsLoad = ld;
    endtask

    task automatic randomizeInputs();
        reset = ($urandom_range(0, 59) == 0);
        stall = ($urandom_range(0, 7) == 0);
        flush = ($urandom_range(0, 9) == 0);
        idOperandAAddr  = RW'($urandom_range(0, 7));
        idOperandBAddr  = RW'($urandom_range(0, 7));
        idDestination   = RW'($urandom_range(0, 7));
        idWeDestination = ($urandom_range(0, 3) != 0);
        idIsLoad        = ($urandom_range(0, 2) == 0);
        idIsJump        = ($urandom_range(0, 7) == 0);
        idUseImmediate  = ($urandom_range(0, 3) == 0);
        idIsStore       = ($urandom_range(0, 3) == 0);
        stageData       = {$urandom, $urandom, $urandom};
        cid             = CW'($urandom_range(0, 1));
        dcacheRegisterAddress = {CW'($urandom_range(0, 1)), RW'($urandom_range(0, 7))};
        dcacheRegisterWe   = ($urandom_range(0, 1) == 1);
        dcacheRegisterData = $urandom;
        writeAddress    = RW'($urandom_range(0, 7));
        writeEnable     = ($urandom_range(0, 1) == 1);
        writeData       = $urandom;
    endtask

    initial begin
        idle();
        stageData = {32'h0000_CCCC, 32'h0000_1234, 32'h0000_AAAA};
        reset = 1;
        modelReset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkEq("rstUseA", exeUseForwardedOpA, 0);
        checkEq("rstUseB", exeUseForwardedOpB, 0);
        checkEq("rstUseS", exeUseForwardedStoreData, 0);
        checkEq("rstHazard", hazardStall, 0);
        checkEq("rstValA", exeOperandA, 32'h0000_AAAA);
        checkEq("rstRfUseA", rfUseForwardedOpA, 0);
        reset = 0;

        // EXE forward: ALU writes r3, next instruction reads r3 as A.
        issue(0, 0, 3, 1, 0); cycle();
        issue(3, 0, 0, 0, 0); cycle();
        issue(0, 0, 0, 0, 0);
        checkEq("fwdUseA", exeUseForwardedOpA, 1);
        checkEq("fwdValA", exeOperandA, 32'h0000_1234);

        // Load-use: load r5 then consume r5 as B; one stall, then forward from slice 2.
        issue(0, 0, 5, 1, 1); cycle();
        issue(0, 5, 6, 1, 0);
        #1 checkEq("luStallFirst", hazardStall, 1);
        cycle();
        checkEq("luBubbleUseB", exeUseForwardedOpB, 0);
        checkEq("luStallSecond", hazardStall, 0);
        cycle();
        issue(0, 0, 0, 0, 0);
        checkEq("luUseB", exeUseForwardedOpB, 1);
        checkEq("luValB", exeOperandB, 32'h0000_CCCC);

        // Priority: two producers of r4, the younger one wins.
        issue(0, 0, 4, 1, 0); cycle();
        issue(0, 0, 4, 1, 0); cycle();
        issue(4, 0, 0, 0, 0); cycle();
        issue(0, 0, 0, 0, 0);
        checkEq("prioValA", exeOperandA, 32'h0000_1234);

        // Register 0 and immediate suppress B forwarding on both paths.
        issue(0, 0, 0, 1, 0); cycle();
        writeAddress = 0; writeEnable = 1; writeData = 32'h5555_0000;
        issue(0, 0, 0, 0, 0);
        #1 checkEq("r0RfUseB", rfUseForwardedOpB, 0);
        cycle();
        checkEq("r0ExeUseB", exeUseForwardedOpB, 0);
        writeAddress = 4; idUseImmediate = 1; issue(0, 4, 0, 0, 0);
        #1 checkEq("immRfUseB", rfUseForwardedOpB, 0);
        cycle();
        idUseImmediate = 0;

        // Dcache return beats the write port when the context matches.
        cid = 3; dcacheRegisterAddress = {4'd3, 5'd7}; dcacheRegisterWe = 1;
        dcacheRegisterData = 32'hDCDC_0001; writeAddress = 7; writeData = 32'h7777_0002;
        issue(7, 0, 0, 0, 0);
        #1 checkEq("dcValA", rfForwardedOperandA, 32'hDCDC_0001);
        cycle();
        cid = 2;
        #1 checkEq("wbValA", rfForwardedOperandA, 32'h7777_0002);
        cycle();
        idle();

        // stall together with flush holds state.
        issue(0, 0, 2, 1, 0); cycle();
        issue(2, 0, 0, 0, 0); stall = 1; flush = 1; cycle(); cycle();
        stall = 0; flush = 0; cycle();

        // Reset during a load-use stall clears the hazard one cycle later.
        issue(0, 0, 5, 1, 1); cycle();
        issue(0, 5, 6, 1, 0);
        #1 checkEq("rstMidStallBefore", hazardStall, 1);
        reset = 1; cycle();
        reset = 0;
        checkEq("rstMidStallAfter", hazardStall, 0);
        cycle();

        for (int i = 0; i < 2000; i++) begin
            randomizeInputs();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
